filter_mode_controller: RTL and testbench

//   Parametrised filter-mode selector for the video effects pipeline.

---
 rtl/filter_mode_controller.sv | 215 +++++++++++++++++++++
 tb/tb_filter_mode_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mode_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | filter_mode_controller: debounced key-driven filter mode select + LCD req  |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module filter_mode_controller #(
  parameter int NUM_MODES       = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  localparam int MODE_W         = $clog2(NUM_MODES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        KEY,
  output logic [MODE_W-1:0] filter_type,
  output logic              mode_changed,
  output logic              locked,
  output logic              lcd_req,
  output logic [MODE_W-1:0] lcd_mode,
  input  logic              lcd_ack
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam logic [CW-1:0]     c_DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]     c_DELAY    = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0]     c_PERIOD   = RW'(REPEAT_PERIOD);
  localparam logic [MODE_W-1:0] c_MAX_MODE = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_REQ    = 2'd1,
    S_RELOAD = 2'd2,
    S_IDLE   = 2'd3
  } state_t;

  logic [3:0] r_sync1, r_sync2;
  logic [3:0] w_deb, w_deb_q, w_press;
  logic [1:0] w_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  assign w_press = w_deb_q & ~w_deb;

  for (genvar k = 0; k < 4; k++) begin : g_key
    logic          r_deb, r_deb_q;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_deb   <= 1'b1;
        r_deb_q <= 1'b1;
        r_cnt   <= '0;
      end else begin
        r_deb_q <= r_deb;
        if (r_sync2[k] != r_deb) begin
          if (r_cnt == c_DEB_LAST) begin
            r_deb <= r_sync2[k];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_deb[k]   = r_deb;
    assign w_deb_q[k] = r_deb_q;
  end

  // r_rcnt holds the number of cycles since the last (real or repeated) press
  for (genvar k = 0; k < 2; k++) begin : g_rpt
    logic          r_first;
    logic [RW-1:0] r_rcnt;
    logic          w_held, w_fire;

    assign w_held   = ~w_deb[k] & ~w_deb_q[k];
    assign w_fire   = w_held & (r_first ? (r_rcnt == c_DELAY) : (r_rcnt == c_PERIOD));
    assign w_evt[k] = w_press[k] | w_fire;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_first <= 1'b0;
        r_rcnt  <= '0;
      end else if (w_press[k]) begin
        r_first <= 1'b1;
        r_rcnt  <= RW'(1);
      end else if (w_held) begin
        if (w_fire) begin
          r_first <= 1'b0;
          r_rcnt  <= RW'(1);
        end else begin
          r_rcnt  <= r_rcnt + 1'b1;
        end
      end else begin
        r_first <= 1'b0;
        r_rcnt  <= '0;
      end
    end
  end

  logic [MODE_W-1:0] r_filter_type, w_ft_nxt;
  logic              r_mode_changed, r_locked, w_lock_nxt;

  always_comb begin
    w_ft_nxt   = r_filter_type;
    w_lock_nxt = r_locked;
    if (w_press[2]) begin
      w_ft_nxt = '0;
    end else if (w_press[3]) begin
      w_lock_nxt = ~r_locked;
    end else if (!r_locked && (w_evt[0] ^ w_evt[1])) begin
      if (w_evt[0]) begin
        w_ft_nxt = (r_filter_type == c_MAX_MODE) ? '0 : r_filter_type + 1'b1;
      end else begin
        w_ft_nxt = (r_filter_type == '0) ? c_MAX_MODE : r_filter_type - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filter_type  <= '0;
      r_mode_changed <= 1'b0;
      r_locked       <= 1'b0;
    end else begin
      r_filter_type  <= w_ft_nxt;
      r_mode_changed <= (w_ft_nxt != r_filter_type);
      r_locked       <= w_lock_nxt;
    end
  end

  state_t            r_state, w_state_nxt;
  logic              r_lcd_req, w_req_nxt, r_pending, w_pend_nxt;
  logic [MODE_W-1:0] r_lcd_mode, w_lmode_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_lcd_req  <= 1'b0;
      r_lcd_mode <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lcd_req  <= w_req_nxt;
      r_lcd_mode <= w_lmode_nxt;
      r_pending  <= w_pend_nxt;
    end
  end

  // A change arriving in the ack cycle is folded into the follow-up request
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_lcd_req;
    w_lmode_nxt = r_lcd_mode;
    w_pend_nxt  = r_pending;
    case (r_state)
      S_INIT: begin
        w_lmode_nxt = '0;
        w_req_nxt   = 1'b1;
        w_pend_nxt  = 1'b0;
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (lcd_ack) begin
          w_req_nxt = 1'b0;
          if (r_pending || r_mode_changed) begin
            w_lmode_nxt = r_filter_type;
            w_pend_nxt  = 1'b0;
            w_state_nxt = S_RELOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (r_mode_changed) begin
          w_pend_nxt = 1'b1;
        end
      end
      S_RELOAD: begin
        w_lmode_nxt = r_filter_type;
        w_req_nxt   = 1'b1;
        w_state_nxt = S_REQ;
      end
      S_IDLE: begin
        if (r_mode_changed) begin
          w_lmode_nxt = r_filter_type;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign filter_type  = r_filter_type;
  assign mode_changed = r_mode_changed;
  assign locked       = r_locked;
  assign lcd_req      = r_lcd_req;
  assign lcd_mode     = r_lcd_mode;

endmodule
`default_nettype wire

// File: tb/tb_filter_mode_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_filter_mode_controller: vectors, corner sequences and random ops        |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_filter_mode_controller;

  localparam int NM = 5, DEB = 4, RD = 20, RP = 8;
  localparam int MW = $clog2(NM);
  localparam int GAP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    KEY = 4'hF;
  logic          lcd_ack = 1'b1;
  logic [MW-1:0] filter_type, lcd_mode;
  logic          mode_changed, locked, lcd_req;

  filter_mode_controller #(
    .NUM_MODES(NM), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .KEY(KEY),
    .filter_type(filter_type), .mode_changed(mode_changed), .locked(locked),
    .lcd_req(lcd_req), .lcd_mode(lcd_mode), .lcd_ack(lcd_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int val; } pulse_t;
  pulse_t pq[$];
  always @(negedge clk) if (mode_changed) pq.push_back('{cyc, int'(filter_type)});

  int checks = 0, errors = 0;
  int m_mode = 0, m_lock = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k, input int hold);
    KEY[k] = 1'b0;
    tick(hold);
    KEY[k] = 1'b1;
    tick(GAP);
  endtask

  // Debounced hold lasts exactly `hold` cycles; repeats land at 20, 28, 36, ...
  function automatic int nrep(input int hold);
    if (hold - 1 >= RD) return 1 + (hold - 1 - RD) / RP;
    return 0;
  endfunction

  task automatic model_op(input int k, input int hold, output int pulses);
    int n;
    pulses = 0;
    case (k)
      2: begin pulses = (m_mode != 0) ? 1 : 0; m_mode = 0; end
      3: m_lock = 1 - m_lock;
      default: if (m_lock == 0) begin
        n = 1 + nrep(hold);
        pulses = n;
        if (k == 0) m_mode = (m_mode + n) % NM;
        else        m_mode = ((m_mode - n) % NM + NM) % NM;
      end
    endcase
  endtask

  typedef struct { int key; int hold; int exp_ft; int exp_lock; int exp_p; } vec_t;
  vec_t vt[15];

  initial begin
    int p0, c0, k, hold, ep;
    int exp_val[4];
    int exp_off[4];
    vt[0]  = '{0, 6, 1, 0, 1};
    vt[1]  = '{0, 6, 2, 0, 1};
    vt[2]  = '{0, 6, 3, 0, 1};
    vt[3]  = '{0, 6, 4, 0, 1};
    vt[4]  = '{0, 6, 0, 0, 1};
    vt[5]  = '{0, 6, 1, 0, 1};
    vt[6]  = '{0, 6, 2, 0, 1};
    vt[7]  = '{3, 6, 2, 1, 0};
    vt[8]  = '{0, 6, 2, 1, 0};
    vt[9]  = '{1, 6, 2, 1, 0};
    vt[10] = '{2, 6, 0, 1, 1};
    vt[11] = '{2, 6, 0, 1, 0};
    vt[12] = '{3, 6, 0, 0, 0};
    vt[13] = '{1, 6, 4, 0, 1};
    vt[14] = '{2, 6, 0, 0, 1};
    exp_val = '{4, 3, 2, 1};
    exp_off = '{0, 20, 28, 36};

    tick(3);
    chk("rst_ft", int'(filter_type), 0);
    chk("rst_mc", int'(mode_changed), 0);
    chk("rst_lock", int'(locked), 0);
    chk("rst_req", int'(lcd_req), 0);
    chk("rst_lmode", int'(lcd_mode), 0);
    rst_n = 1'b1;
    tick(1);
    chk("init_req", int'(lcd_req), 1);
    chk("init_lmode", int'(lcd_mode), 0);
    tick(3);
    chk("init_done", int'(lcd_req), 0);

    foreach (vt[i]) begin
      p0 = pq.size();
      press(vt[i].key, vt[i].hold);
      chk($sformatf("vec%0d_ft", i), int'(filter_type), vt[i].exp_ft);
      chk($sformatf("vec%0d_lock", i), int'(locked), vt[i].exp_lock);
      chk($sformatf("vec%0d_pulses", i), pq.size() - p0, vt[i].exp_p);
      chk($sformatf("vec%0d_lmode", i), int'(lcd_mode), vt[i].exp_ft);
    end

    // glitch rejection, then exact key-to-mode latency
    p0 = pq.size();
    KEY[0] = 1'b0; tick(3); KEY[0] = 1'b1; tick(8);
    chk("glitch_ft", int'(filter_type), 0);
    KEY[0] = 1'b0; tick(6); KEY[0] = 1'b1;
    chk("lat_before", int'(filter_type), 0);
    tick(1);
    chk("lat_at", int'(filter_type), 1);
    chk("lat_mc", int'(mode_changed), 1);
    tick(1);
    chk("lat_mc_pulse", int'(mode_changed), 0);
    tick(GAP);
    chk("glitch_pulses", pq.size() - p0, 1);

    press(2, 6);
    chk("home_ft", int'(filter_type), 0);

    // auto-repeat on prev held 40 cycles
    pq.delete();
    c0 = cyc;
    KEY[1] = 1'b0; tick(40); KEY[1] = 1'b1; tick(20);
    chk("rep_count", pq.size(), 4);
    if (pq.size() > 0) chk("rep_first_lat", pq[0].cyc - c0, 2 + DEB + 1);
    for (int i = 0; i < 4 && i < pq.size(); i++) begin
      chk($sformatf("rep%0d_val", i), pq[i].val, exp_val[i]);
      chk($sformatf("rep%0d_off", i), pq[i].cyc - pq[0].cyc, exp_off[i]);
    end

    // coalesced LCD updates with ack withheld
    press(2, 6);
    lcd_ack = 1'b0;
    press(0, 6);
    chk("lcd1_req", int'(lcd_req), 1);
    chk("lcd1_mode", int'(lcd_mode), 1);
    press(0, 6);
    chk("lcd2_mode", int'(lcd_mode), 1);
    press(0, 6);
    chk("lcd3_ft", int'(filter_type), 3);
    chk("lcd3_req", int'(lcd_req), 1);
    chk("lcd3_mode", int'(lcd_mode), 1);
    lcd_ack = 1'b1; tick(1); lcd_ack = 1'b0;
    chk("ack_drop", int'(lcd_req), 0);
    tick(1);
    chk("reload_req", int'(lcd_req), 1);
    chk("reload_mode", int'(lcd_mode), 3);
    lcd_ack = 1'b1; tick(1); lcd_ack = 1'b0;
    chk("ack2_drop", int'(lcd_req), 0);
    tick(6);
    chk("no_extra_req", int'(lcd_req), 0);

    // reset mid-request
    press(1, 6);
    press(0, 6);
    chk("pre_rst_ft", int'(filter_type), 3);
    chk("pre_rst_req", int'(lcd_req), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ft", int'(filter_type), 0);
    chk("arst_req", int'(lcd_req), 0);
    chk("arst_lmode", int'(lcd_mode), 0);
    chk("arst_mc", int'(mode_changed), 0);
    chk("arst_lock", int'(locked), 0);
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("reinit_req", int'(lcd_req), 1);
    chk("reinit_mode", int'(lcd_mode), 0);
    lcd_ack = 1'b1;
    tick(1);
    chk("reinit_ack", int'(lcd_req), 0);
    tick(5);
    chk("reinit_once", int'(lcd_req), 0);

    // random single-key operations against the arithmetic model
    m_mode = 0;
    m_lock = 0;
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 3);
      hold = (k < 2) ? $urandom_range(6, 45) : $urandom_range(6, 12);
      p0 = pq.size();
      press(k, hold);
      model_op(k, hold, ep);
      chk($sformatf("rnd%0d_k%0d_h%0d_ft", i, k, hold), int'(filter_type), m_mode);
      chk($sformatf("rnd%0d_lock", i), int'(locked), m_lock);
      chk($sformatf("rnd%0d_pulses", i), pq.size() - p0, ep);
      chk($sformatf("rnd%0d_lmode", i), int'(lcd_mode), m_mode);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
